// File: rtl/ps2_tx_multi.sv
// ps2_tx_multi: multi-channel PS/2 device-side transmitter, one FIFO and framer per channel.
// Define PS2_TX_INHIBIT_EN to enable host-inhibit abort with retransmit via ps2_clk_in.
module ps2_tx_multi #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned FIFO_BITS = 3,
  parameter int unsigned PS2DIV    = 100
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [CHANNELS-1:0]     wr,
  input  logic [8*CHANNELS-1:0]   wr_data,
  output logic [CHANNELS-1:0]     full,
  output logic [CHANNELS-1:0]     empty,
  output logic [CHANNELS-1:0]     overflow,
  input  logic [CHANNELS-1:0]     ovf_clr,
  output logic [CHANNELS-1:0]     busy,
  output logic [CHANNELS-1:0]     ps2_clk,
  output logic [CHANNELS-1:0]     ps2_data,
  input  logic [CHANNELS-1:0]     ps2_clk_in
);

  localparam int unsigned DEPTH = 1 << FIFO_BITS;
  localparam int unsigned CW    = FIFO_BITS + 1;
  localparam int unsigned DIV_W = (PS2DIV > 2) ? $clog2(PS2DIV) : 1;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_PAR  = 4'd9;
  localparam logic [3:0] S_STOP = 4'd10;
  localparam logic [3:0] S_DONE = 4'd11;

  logic [DIV_W-1:0] div_cnt;
  logic             clk_ps2;
  logic             div_wrap_c;
  logic             clk_ps2_nxt_c;
  logic             tick_c;

  assign div_wrap_c    = (div_cnt == DIV_W'(PS2DIV - 1));
  assign clk_ps2_nxt_c = div_wrap_c ? ~clk_ps2 : clk_ps2;
  assign tick_c        = div_wrap_c & ~clk_ps2;

  // Shared divider: clk_ps2 toggles on every wrap, tick marks its rising edge
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_cnt <= '0;
      clk_ps2 <= 1'b0;
    end else begin
      div_cnt <= div_wrap_c ? '0 : div_cnt + DIV_W'(1);
      clk_ps2 <= clk_ps2_nxt_c;
    end
  end

`ifndef PS2_TX_INHIBIT_EN
  // ps2_clk_in has no function when host inhibit is not built
  logic unused_ps2_clk_in;
  assign unused_ps2_clk_in = ^ps2_clk_in;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [7:0]           mem [DEPTH];
    logic [FIFO_BITS-1:0] wptr, wptr_nxt, rptr, rptr_nxt;
    logic [CW-1:0]        count, count_nxt;
    logic [3:0]           state, state_nxt;
    logic [7:0]           shift, shift_nxt;
    logic                 parity, parity_nxt;
    logic                 data_nxt, ovf_nxt;
    logic                 push_c, pop_c, line_ok_c, abort_c;
    logic                 full_q, empty_q, ovf_q, busy_q, clk_q, data_q;

`ifdef PS2_TX_INHIBIT_EN
    logic [1:0] inh_sync;
    always_ff @(posedge clk_sys) begin
      if (reset) inh_sync <= 2'b11;
      else       inh_sync <= {inh_sync[0], ps2_clk_in[i]};
    end
    assign line_ok_c = inh_sync[1];
`else
    assign line_ok_c = 1'b1;
`endif

    // Fullness is judged before any same-cycle pop
    assign push_c  = wr[i] & (count != CW'(DEPTH));
    assign abort_c = ~line_ok_c & clk_ps2 & (state != S_IDLE) & (state <= S_PAR);

    always_comb begin
      state_nxt  = state;
      shift_nxt  = shift;
      parity_nxt = parity;
      data_nxt   = data_q;
      rptr_nxt   = rptr;
      pop_c      = 1'b0;
      if (abort_c) begin
        state_nxt = S_IDLE;
        data_nxt  = 1'b1;
      end else if (tick_c) begin
        case (state)
          S_IDLE: begin
            if ((count != '0) && line_ok_c) begin
              shift_nxt  = mem[rptr];
              parity_nxt = 1'b1;
              data_nxt   = 1'b0;
              state_nxt  = 4'd1;
            end
          end
          4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
            data_nxt   = shift[0];
            shift_nxt  = {1'b0, shift[7:1]};
            parity_nxt = parity ^ shift[0];
            state_nxt  = state + 4'd1;
          end
          S_PAR: begin
            data_nxt  = parity;
            state_nxt = S_STOP;
          end
          S_STOP: begin
            data_nxt  = 1'b1;
            pop_c     = 1'b1;
            rptr_nxt  = rptr + FIFO_BITS'(1);
            state_nxt = S_DONE;
          end
          default: state_nxt = S_IDLE;
        endcase
      end
      wptr_nxt  = push_c ? wptr + FIFO_BITS'(1) : wptr;
      count_nxt = count + CW'(push_c) - CW'(pop_c);
      // A dropped write wins over a same-cycle clear
      ovf_nxt   = (wr[i] & ~push_c) | (ovf_q & ~ovf_clr[i]);
    end

    always_ff @(posedge clk_sys) begin
      if (push_c) mem[wptr] <= wr_data[8*i +: 8];
    end

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        state   <= S_IDLE;
        shift   <= '0;
        parity  <= 1'b0;
        wptr    <= '0;
        rptr    <= '0;
        count   <= '0;
        ovf_q   <= 1'b0;
        full_q  <= 1'b0;
        empty_q <= 1'b1;
        busy_q  <= 1'b0;
        clk_q   <= 1'b1;
        data_q  <= 1'b1;
      end else begin
        state   <= state_nxt;
        shift   <= shift_nxt;
        parity  <= parity_nxt;
        wptr    <= wptr_nxt;
        rptr    <= rptr_nxt;
        count   <= count_nxt;
        ovf_q   <= ovf_nxt;
        full_q  <= (count_nxt == CW'(DEPTH));
        empty_q <= (count_nxt == '0);
        busy_q  <= (state_nxt != S_IDLE);
        clk_q   <= clk_ps2_nxt_c | (state_nxt == S_IDLE);
        data_q  <= data_nxt;
      end
    end

    assign full[i]     = full_q;
    assign empty[i]    = empty_q;
    assign overflow[i] = ovf_q;
    assign busy[i]     = busy_q;
    assign ps2_clk[i]  = clk_q;
    assign ps2_data[i] = data_q;
  end

endmodule

// File: tb/tb_ps2_tx_multi.sv
// tb_ps2_tx_multi: scoreboard bench for ps2_tx_multi (2 channels, 8-deep FIFOs, PS2DIV=4).
module tb_ps2_tx_multi;

  localparam int unsigned CH     = 2;
  localparam int unsigned DIV    = 4;
  localparam int unsigned TICK_P = 2 * DIV;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic [CH-1:0] wr, ovf_clr, ps2_clk_in;
  logic [8*CH-1:0] wr_data;
  logic [CH-1:0] full, empty, overflow, busy, ps2_clk, ps2_data;

  ps2_tx_multi #(.CHANNELS(CH), .FIFO_BITS(3), .PS2DIV(DIV)) dut (
    .clk_sys(clk_sys), .reset(reset), .wr(wr), .wr_data(wr_data),
    .full(full), .empty(empty), .overflow(overflow), .ovf_clr(ovf_clr),
    .busy(busy), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ps2_clk_in(ps2_clk_in)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0]  exp_q0[$];
  logic [7:0]  exp_q1[$];
  logic        prev_clk [CH] = '{1'b1, 1'b1};
  int          nbits [CH]    = '{0, 0};
  logic [10:0] frame [CH];
  int          last_start [CH] = '{0, 0};
  int          prev_start [CH] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int ch, input logic [7:0] b);
    if (ch == 0) exp_q0.push_back(b);
    else         exp_q1.push_back(b);
  endtask

  // Compare a received 11-bit frame (bit 0 = start) with the oldest expected byte
  task automatic check_frame(input int ch, input logic [10:0] f);
    logic [7:0]  b;
    logic [10:0] ef;
    int          qs;
    qs = (ch == 0) ? exp_q0.size() : exp_q1.size();
    check($sformatf("frame_expected_ch%0d", ch), 32'(qs != 0), 32'd1);
    if (qs != 0) begin
      b  = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      ef = {1'b1, ~^b, b, 1'b0};
      check($sformatf("frame_ch%0d", ch), 32'(f), 32'(ef));
    end
  endtask

  // Consumer model: sample ps2_data on each ps2_clk falling edge
  always @(negedge clk_sys) begin
    cyc++;
    for (int c = 0; c < CH; c++) begin
      if (reset) begin
        nbits[c]    = 0;
        prev_clk[c] = 1'b1;
      end else begin
        if (prev_clk[c] && !ps2_clk[c]) begin
          if (nbits[c] == 0) begin
            prev_start[c] = last_start[c];
            last_start[c] = cyc;
          end
          frame[c][nbits[c]] = ps2_data[c];
          nbits[c]++;
          if (nbits[c] == 11) begin
            check_frame(c, frame[c]);
            nbits[c] = 0;
          end
        end
        prev_clk[c] = ps2_clk[c];
      end
    end
  end

  task automatic write_byte(input int ch, input logic [7:0] b, input bit accept);
    @(negedge clk_sys);
    wr                 = '0;
    wr[ch]             = 1'b1;
    wr_data[8*ch +: 8] = b;
    if (accept) push_exp(ch, b);
  endtask

  task automatic end_writes();
    @(negedge clk_sys);
    wr      = '0;
    ovf_clr = '0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || busy != '0) && k < budget) begin
      @(negedge clk_sys);
      k++;
    end
    check(tag, 32'(k < budget), 32'd1);
  endtask

  initial begin
    int  busy_cnt, diffs, k;
    bit  seen;
    reset      = 1'b1;
    wr         = '0;
    wr_data    = '0;
    ovf_clr    = '0;
    ps2_clk_in = '1;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check("rst_ps2_clk",  32'(ps2_clk),  32'h3);
    check("rst_ps2_data", 32'(ps2_data), 32'h3);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_empty",    32'(empty),    32'h3);
    check("rst_full",     32'(full),     32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);

    // Single byte 0xA5: frame 0,1,0,1,0,0,1,0,1,1,1 and busy for 11 ticks
    write_byte(0, 8'hA5, 1'b1);
    end_writes();
    check("empty_after_wr", 32'(empty[0]), 32'd0);
    busy_cnt = 0;
    seen     = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (busy[0]) begin
        busy_cnt++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
      @(negedge clk_sys);
    end
    check("busy_len", 32'(busy_cnt), 32'(11 * TICK_P));
    check("empty_after_stop", 32'(empty[0]), 32'd1);
    wait_idle("drain_a5", 200);

    // Nine back-to-back writes into an 8-deep FIFO: the ninth is dropped
    for (int n = 0; n < 9; n++) write_byte(0, 8'(n), n < 8);
    end_writes();
    check("ovf_full",     32'(full[0]),     32'd1);
    check("ovf_set",      32'(overflow[0]), 32'd1);
    ovf_clr[0] = 1'b1;
    @(negedge clk_sys);
    ovf_clr = '0;
    check("ovf_cleared",  32'(overflow[0]), 32'd0);
    write_byte(0, 8'h09, 1'b0);
    ovf_clr[0] = 1'b1;
    end_writes();
    check("ovf_set_wins", 32'(overflow[0]), 32'd1);
    check("ovf_still_full", 32'(full[0]),   32'd1);
    ovf_clr[0] = 1'b1;
    @(negedge clk_sys);
    ovf_clr = '0;
    check("ovf_cleared2", 32'(overflow[0]), 32'd0);
    wait_idle("drain_ovf", 9 * 12 * TICK_P + 200);
    check("empty_after_ovf", 32'(empty[0]), 32'd1);

    // Same-cycle writes on both channels run with identical clocks
    @(negedge clk_sys);
    wr      = 2'b11;
    wr_data = {8'hF0, 8'h12};
    push_exp(0, 8'h12);
    push_exp(1, 8'hF0);
    @(negedge clk_sys);
    wr    = '0;
    diffs = 0;
    for (int n = 0; n < 13 * TICK_P; n++) begin
      if (ps2_clk[0] !== ps2_clk[1]) diffs++;
      @(negedge clk_sys);
    end
    check("clk_match", 32'(diffs), 32'd0);
    wait_idle("drain_dual", 200);

    // Reset during data bit 4 abandons the frame
    write_byte(0, 8'h3C, 1'b1);
    end_writes();
    k = 0;
    while (!busy[0] && k < 50) begin
      @(negedge clk_sys);
      k++;
    end
    check("busy_rise", 32'(busy[0]), 32'd1);
    repeat (4 * TICK_P + 2) @(negedge clk_sys);
    reset = 1'b1;
    exp_q0.delete();
    @(negedge clk_sys);
    reset = 1'b0;
    check("midrst_ps2_clk",  32'(ps2_clk),  32'h3);
    check("midrst_ps2_data", 32'(ps2_data), 32'h3);
    check("midrst_busy",     32'(busy),     32'h0);
    check("midrst_empty",    32'(empty),    32'h3);
    write_byte(0, 8'h55, 1'b1);
    end_writes();
    wait_idle("drain_55", 200);

    // Back-to-back bytes: start bits exactly 12 ticks apart
    write_byte(1, 8'h01, 1'b1);
    write_byte(1, 8'h02, 1'b1);
    end_writes();
    wait_idle("drain_b2b", 400);
    check("b2b_gap", 32'(last_start[1] - prev_start[1]), 32'(12 * TICK_P));
    check("ovf1_clear", 32'(overflow[1]), 32'd0);
    check("final_empty", 32'(empty), 32'h3);

    repeat (4) @(negedge clk_sys);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_tx_multi.md
# ps2_tx_multi

Parametrised multi-channel PS/2 device-side transmitter for the ARM-to-core input path. Bytes decoded from the SPI command stream (keyboard, mouse, further pointing devices) are written into per-channel FIFOs of configurable depth. Each channel serialises its bytes onto an open-collector-style PS/2 clock/data pair, driven by one shared clock divider. Compared with the fixed two-channel, 8-deep transmitter it replaces, this block adds:
- a configurable channel count;
- a full flag and a sticky overflow flag per channel;
- optional host-inhibit abort with retransmit.

## Interface
Parameters:
- CHANNELS, 2, number of independent PS/2 transmit channels (1..8)
- FIFO_BITS, 3, log2 of FIFO depth per channel; DEPTH = 2**FIFO_BITS (1..6)
- PS2DIV, 100, clk_sys cycles per PS/2 clock half-period; minimum 2

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- wr  in  CHANNELS  write strobe per channel, one byte per asserted cycle
- wr_data  in  8*CHANNELS  packed write bytes; channel i at [8i+7:8i]
- full  out  CHANNELS  FIFO holds DEPTH bytes
- empty  out  CHANNELS  FIFO holds 0 bytes (byte in flight counts as held)
- overflow  out  CHANNELS  sticky: a write was dropped
- ovf_clr  in  CHANNELS  clears overflow
- busy  out  CHANNELS  frame in progress (state != IDLE)
- ps2_clk  out  CHANNELS  PS/2 clock to device consumer
- ps2_data  out  CHANNELS  PS/2 data to device consumer
- ps2_clk_in  in  CHANNELS  sensed PS/2 clock line for host inhibit (used only with PS2_TX_INHIBIT_EN)

Clock and reset: one clock, clk_sys. Reset is synchronous and active-high, on port reset.

## Operation
- **Divider**
  - Shared counter 0..PS2DIV-1 drives an internal clock clk_ps2.
  - clk_ps2 toggles when the counter wraps.
  - tick is a one-cycle pulse on the cycle where clk_ps2 goes 0->1.
  - All channel state machines advance only on tick.
- **FIFO per channel**
  - wptr, rptr and count, with count FIFO_BITS+1 bits wide.
  - Write when wr[i] and count<DEPTH.
  - When wr[i] and count==DEPTH, the byte is dropped and overflow[i] is set.
  - Fullness is evaluated before any same-cycle pop, so a write to a full FIFO is dropped even if a pop occurs that cycle.
  - The head byte is not popped at load. rptr advances on the tick leaving STOP, so an aborted byte is retransmitted.
- **State machine per channel** (4-bit state)
  - IDLE(0): on tick with count!=0 (and not inhibited), load shift register from FIFO head, parity<=1, ps2_data<=0 (start bit), go to 1.
  - 1..8: ps2_data<=shift[0], shift right, parity^=shift[0].
  - 9: ps2_data<=parity (odd parity: 1 XOR all data bits).
  - 10: ps2_data<=1 (stop bit); pop FIFO; go to 11.
  - 11: go to IDLE.
- **Outputs**
  - ps2_clk[i] = clk_ps2 | (state==IDLE).
  - busy[i] = (state!=IDLE).
  - ps2_data idles at 1.
- **Overflow**: set has priority over ovf_clr in the same cycle.
- **Channel independence**: channels are independent. Simultaneous writes to all channels are all accepted.

## Timing
- Reset values:
  - ps2_clk all 1, ps2_data all 1, busy 0;
  - empty all 1, full 0, overflow 0;
  - divider 0, clk_ps2 0, all FIFOs emptied.
- Reset mid-frame aborts the frame. Outputs return to reset values on the next edge, and the in-flight byte is lost.
- tick period = 2*PS2DIV clk_sys cycles.
- A frame is 11 bits plus 1 trailing idle tick = 12 ticks.
- Write-to-start-bit latency: the write is visible on the next cycle; the start bit appears on the first tick after that with state IDLE.
- full/empty/overflow update on the cycle after the write or pop.
- ps2_data changes on the same clk_sys edge that drives ps2_clk high. The consumer samples on the ps2_clk falling edge.
- Back-to-back bytes: the next start bit occurs at the IDLE tick immediately following state 11.

## Configuration
- PS2_TX_INHIBIT_EN defined:
  - ps2_clk_in passes through a 2-flop synchroniser.
  - When the synchronised line is 0 while clk_ps2 is 1 and state is in 1..9, the channel aborts on the next cycle: state<=IDLE, ps2_data<=1, no pop.
  - While the synchronised line is 0, IDLE does not start a frame.
  - States 10 and 11 complete normally.
- Undefined: ps2_clk_in is ignored and no synchroniser is built. Behaviour is identical to an always-high line.

## Test plan
- CHANNELS=1, PS2DIV=4, write 0xA5 -> ps2_data sampled on ps2_clk falling edges = 0,1,0,1,0,0,1,0,1,1,1. busy is high for 11 ticks. empty returns to 1 after the stop tick.
- FIFO_BITS=3, 9 consecutive writes 0x00..0x08 with tx running -> 9th dropped, full=1, overflow=1. Output stream is 0x00..0x07. ovf_clr clears overflow; ovf_clr together with a dropped write leaves overflow=1.
- CHANNELS=2, same-cycle writes 0x12 to ch0 and 0xF0 to ch1 -> both frames start on the same tick with identical ps2_clk waveforms and correct independent data/parity.
- Reset asserted during data bit 4 -> next cycle ps2_clk=1, ps2_data=1, busy=0, empty=1. A fresh write of 0x55 afterwards transmits cleanly.
- With PS2_TX_INHIBIT_EN: write 0x3C, pull ps2_clk_in low during bit 3 for 3 ticks -> abort, no frame while held low, then full retransmit of 0x3C and a single pop.
- Back-to-back 0x01,0x02 -> second start bit exactly 12 ticks after the first.
